// File: rtl/in_ctrl_pkg.sv
// Shared definitions for the input latch controller and the CPU decoder:
// state encoding and default data/switch widths.
package in_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SW_W_DEF   = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_WAIT    = S_WAIT,
    ST_ACK     = S_ACK,
    ST_RELEASE = S_RELEASE
  } state_e;

endpackage

// File: rtl/input_latch_ctrl_if.sv
// CPU-side input handshake bundle: request/acknowledge, returned word and
// status flags. master = CPU, slave = input latch controller.
interface input_latch_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_req;
  logic              in_ack;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              waiting;
  logic              pending;
  logic              overrun;

  modport master (
    output in_req,
    input  in_ack, in_data, stall, waiting, pending, overrun
  );

  modport slave (
    input  in_req,
    output in_ack, in_data, stall, waiting, pending, overrun
  );
endinterface

// File: rtl/input_latch_ctrl_rise_detect.sv
// Rising-edge detector for the debounced press level. The history register
// resets to 1 so a press already held when reset releases is not a new press.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic press_i,
  output logic rise_o
);

  logic press_q;

  // Previous-cycle press level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) press_q <= 1'b1;
    else        press_q <= press_i;
  end

  assign rise_o = press_i & ~press_q;

endmodule

// File: rtl/input_latch_ctrl.sv
// Input latch controller: turns each debounced press into a one-shot capture
// of the switch bank, buffers it, and hands it to the CPU INPUT instruction,
// stalling the CPU while no word is available.
module input_latch_ctrl
  import in_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SW_W     = SW_W_DEF,
  parameter int SIGN_EXT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                press,
  input  logic [SW_W-1:0]     switches,
  input_latch_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] sw_ext;
  logic              rise;
  logic              consumed;

  rise_detect u_rise_detect (
    .clk     (clk),
    .rst_n   (rst_n),
    .press_i (press),
    .rise_o  (rise)
  );

  // Extend the switch bank to the CPU word width (sign or zero fill).
  always_comb begin
    sw_ext             = {DATA_W{(SIGN_EXT != 0) && switches[SW_W-1]}};
    sw_ext[SW_W-1:0]   = switches;
  end

  // Next-state, data load and buffer/pending/overrun bookkeeping.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    buf_d     = buf_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    consumed  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_req) begin
          consumed = 1'b1;
          if (pending_q || rise) begin
            // A fresh press beats an older buffered word.
            in_data_d = rise ? sw_ext : buf_q;
            state_d   = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.in_req) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          consumed  = 1'b1;
          in_data_d = sw_ext;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        pending_d = 1'b0;
        overrun_d = 1'b0;
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus.in_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rise) buf_d = sw_ext;

    // A press not handed straight to the CPU is buffered; newest wins. A press
    // during ACK lands after the old word was consumed, so it is not an overrun.
    if (rise && !consumed) begin
      pending_d = 1'b1;
      overrun_d = (state_q == ST_ACK) ? 1'b0 : (overrun_q | pending_q);
    end
  end

  // State and data registers; reset discards any buffered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      buf_q     <= '0;
      in_data_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      in_data_q <= in_data_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.in_ack  = (state_q == ST_ACK);
  assign bus.in_data = in_data_q;
  assign bus.waiting = (state_q == ST_WAIT);
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;
  assign bus.stall   = bus.in_req & (state_q != ST_ACK) & (state_q != ST_RELEASE);

endmodule

// File: tb/tb_input_latch_ctrl.sv
// Directed bench for input_latch_ctrl (SIGN_EXT=1, 32-bit word, 16 switches).
module tb_input_latch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        press;
  logic [15:0] switches;

  int checks = 0;
  int errors = 0;

  input_latch_ctrl_if #(.DATA_W(32)) bus ();

  input_latch_ctrl #(
    .DATA_W   (32),
    .SW_W     (16),
    .SIGN_EXT (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .press    (press),
    .switches (switches),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_stall;
  int n_ack;

  initial begin
    rst_n       = 1'b0;
    press       = 1'b1;
    switches    = 16'h0000;
    bus.in_req  = 1'b0;

    // Reset with press held; release must not produce a press.
    repeat (3) tick();
    check("rst_in_ack",  {31'd0, bus.in_ack},  32'd0);
    check("rst_in_data", bus.in_data,          32'd0);
    check("rst_waiting", {31'd0, bus.waiting}, 32'd0);
    check("rst_pending", {31'd0, bus.pending}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("rst_stall",   {31'd0, bus.stall},   32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("held_press_pending", {31'd0, bus.pending}, 32'd0);
    press = 1'b0;
    tick();

    // Waiting case: request first, 3-cycle press 4 cycles later, sign-extended.
    switches   = 16'h8001;
    bus.in_req = 1'b1;
    n_stall    = 0;
    n_ack      = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) press = 1'b1;
      if (c == 7) begin
        press      = 1'b0;
        bus.in_req = 1'b0;
      end
      #1;
      if (bus.stall) n_stall++;
      if (bus.in_ack) begin
        n_ack++;
        check("wait_in_data", bus.in_data, 32'hFFFF8001);
      end
      if (c == 2) check("wait_waiting", {31'd0, bus.waiting}, 32'd1);
      if (c == 5) check("wait_ack_cycle", {31'd0, bus.in_ack}, 32'd1);
      tick();
    end
    check("wait_stall_cycles", n_stall, 32'd5);
    check("wait_ack_count",    n_ack,   32'd1);
    check("wait_waiting_after", {31'd0, bus.waiting}, 32'd0);
    check("wait_no_pending",   {31'd0, bus.pending}, 32'd0);

    // Buffered case: press without request, switches change afterwards.
    switches = 16'h0042;
    press    = 1'b1;
    tick();
    press    = 1'b0;
    switches = 16'h1234;
    repeat (10) tick();
    check("buf_pending", {31'd0, bus.pending}, 32'd1);
    bus.in_req = 1'b1;
    #1;
    check("buf_stall_req", {31'd0, bus.stall}, 32'd1);
    tick();
    check("buf_in_ack",  {31'd0, bus.in_ack}, 32'd1);
    check("buf_in_data", bus.in_data, 32'h00000042);
    check("buf_stall_ack", {31'd0, bus.stall}, 32'd0);
    tick();
    check("buf_ack_one_shot", {31'd0, bus.in_ack},  32'd0);
    check("buf_pending_clr",  {31'd0, bus.pending}, 32'd0);
    bus.in_req = 1'b0;
    tick();

    // Overrun: two presses before any request; newest wins.
    switches = 16'h0001; press = 1'b1; tick();
    press    = 1'b0;                   tick();
    switches = 16'h0002; press = 1'b1; tick();
    press    = 1'b0;                   tick();
    check("ovr_overrun", {31'd0, bus.overrun}, 32'd1);
    check("ovr_pending", {31'd0, bus.pending}, 32'd1);
    bus.in_req = 1'b1;
    tick();
    check("ovr_in_ack",  {31'd0, bus.in_ack}, 32'd1);
    check("ovr_in_data", bus.in_data, 32'h00000002);
    tick();
    check("ovr_overrun_clr", {31'd0, bus.overrun}, 32'd0);
    check("ovr_pending_clr", {31'd0, bus.pending}, 32'd0);
    bus.in_req = 1'b0;
    tick();

    // Request held high across the ack for 6 cycles.
    switches = 16'h0055; press = 1'b1; tick();
    press    = 1'b0;                   tick();
    bus.in_req = 1'b1;
    n_stall = 0;
    n_ack   = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.stall)  n_stall++;
      if (bus.in_ack) n_ack++;
      tick();
    end
    check("hold_ack_count",   n_ack,   32'd1);
    check("hold_stall_count", n_stall, 32'd1);
    check("hold_in_data",     bus.in_data, 32'h00000055);
    bus.in_req = 1'b0;
    tick();

    // Enter WAIT, then reset asynchronously mid-cycle.
    bus.in_req = 1'b1;
    #1;
    check("rw_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    check("rw_waiting", {31'd0, bus.waiting}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_waiting", {31'd0, bus.waiting}, 32'd0);
    check("arst_in_data", bus.in_data,          32'd0);
    check("arst_in_ack",  {31'd0, bus.in_ack},  32'd0);
    check("arst_pending", {31'd0, bus.pending}, 32'd0);
    check("arst_overrun", {31'd0, bus.overrun}, 32'd0);
    bus.in_req = 1'b0;
    #1;
    check("arst_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    switches = 16'h0077; press = 1'b1; tick();
    press    = 1'b0;
    check("post_rst_pending", {31'd0, bus.pending}, 32'd1);
    check("post_rst_waiting", {31'd0, bus.waiting}, 32'd0);
    check("post_rst_in_ack",  {31'd0, bus.in_ack},  32'd0);
    bus.in_req = 1'b1;
    tick();
    check("post_rst_ack",     {31'd0, bus.in_ack}, 32'd1);
    check("post_rst_in_data", bus.in_data, 32'h00000077);
    tick();
    bus.in_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
